arp_tx: RTL
===========

Name: arp_tx

Overview:
- ARP transmit engine; the counterpart of the ARP receive path.
- Serialises ARP reply frames (on the receive path's reply request) and ARP request frames (on the address-resolution request) as a byte stream into the MAC transmit arbiter.
- Supplies the Ethernet destination MAC for the frame header.
- The stream is the 28-byte ARP body, zero-padded to the minimum Ethernet payload.

Parameters:
- PAYLOAD_LEN, 46: bytes emitted per frame (28 ARP + padding); legal range 28..255.
- GRANT_TIMEOUT, 1024: cycles to wait for the MAC grant; used only with ARP_TX_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- local_ip_addr  in  32  our IP (SPA).
- local_mac_addr  in  48  our MAC (SHA).
- arp_reply_req  in  1  level; send reply; held until ack.
- arp_reply_ack  out  1  1-cycle pulse; reply accepted.
- arp_rec_source_ip_addr  in  32  requester IP, becomes reply TPA.
- arp_rec_source_mac_addr  in  48  requester MAC, becomes reply THA and Ethernet destination.
- arp_request_req  in  1  level; resolve arp_request_ip_addr; held until ack.
- arp_request_ack  out  1  1-cycle pulse; request accepted.
- arp_request_ip_addr  in  32  target IP for the request.
- arp_tx_req  out  1  frame pending to the MAC.
- arp_tx_ready  in  1  MAC grant; sampled only in WAIT_GRANT.
- arp_tx_data  out  8  payload byte.
- arp_tx_valid  out  1  arp_tx_data valid; one byte per cycle, no backpressure.
- arp_tx_end  out  1  high with the last byte.
- arp_tx_dst_mac  out  48  Ethernet destination; stable from accept until the next accept.
- arp_tx_busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: state IDLE; all outputs 0; latched fields 0.
- Reset mid-frame aborts at the next edge: arp_tx_valid and arp_tx_end drop, and no ack is re-issued.
- FSM states (one-hot): IDLE, WAIT_GRANT, SEND, END.
- IDLE:
  - If arp_reply_req, latch the reply operands and pulse arp_reply_ack.
  - Otherwise, if arp_request_req, latch the request operands and pulse arp_request_ack.
  - Reply wins when both are high; the request stays pending and is served after the reply frame completes.
  - Either accept moves to WAIT_GRANT.
- Latched operands:
  - Reply: op=0x0002; THA=arp_rec_source_mac_addr; TPA=arp_rec_source_ip_addr; dst_mac=THA.
  - Request: op=0x0001; THA=0; TPA=arp_request_ip_addr; dst_mac=FF:FF:FF:FF:FF:FF.
  - SHA and SPA are latched from local_* at the same edge. Later input changes do not affect the frame in flight.
- WAIT_GRANT: arp_tx_req=1. When arp_tx_ready is sampled 1, go to SEND with cnt=0; arp_tx_req falls on that edge.
- SEND:
  - arp_tx_valid=1 and cnt increments every cycle.
  - Byte map, MSB first:
    - 0-1: 0x0001
    - 2-3: 0x0800
    - 4: 0x06
    - 5: 0x04
    - 6-7: op
    - 8-13: SHA
    - 14-17: SPA
    - 18-23: THA
    - 24-27: TPA
    - 28..PAYLOAD_LEN-1: 0x00
  - arp_tx_end=1 when cnt==PAYLOAD_LEN-1; next state is END.
- END: one cycle, outputs idle; then IDLE. Back-to-back frames are therefore separated by at least 2 idle cycles (END, IDLE accept).
- Latency:
  - req high in IDLE → ack the same cycle (registered, visible the next cycle).
  - arp_tx_req asserts the cycle after the accept.
  - First byte appears the cycle after the grant is sampled.
- Counter: cnt is 8 bits, cleared outside SEND; it never wraps because PAYLOAD_LEN ≤ 255.
- Requests that assert while busy wait; no ack is given until accepted in IDLE.

Optional Feature:
- Macro: ARP_TX_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in WAIT_GRANT.
  - When it reaches GRANT_TIMEOUT-1 without a grant, drop arp_tx_req, discard the frame, go to IDLE, and pulse arp_tx_timeout (extra 1-bit output, reset 0) for one cycle.
  - If the grant and the timeout coincide, the grant wins.
- Undefined: WAIT_GRANT waits indefinitely; the arp_tx_timeout port is absent.

Decomposition:
- Shared package arp_pkg:
  - ARP_HTYPE_ETH=16'h0001, ARP_PTYPE_IPV4=16'h0800, ARP_HLEN=8'h06, ARP_PLEN=8'h04.
  - ARP_REQUEST_CODE=16'h0001, ARP_REPLY_CODE=16'h0002, ARP_BCAST_MAC=48'hFFFF_FFFF_FFFF.
  - State encoding constants.
  - Byte-offset constants shared with the receive path.
- One sub-module, arp_tx_mux: combinational byte selector from {cnt, latched fields} to arp_tx_data. The FSM stays in arp_tx.

Test Plan:
- Reply: local IP C0A80002, local MAC 000A35010203; arp_reply_req with src IP C0A80003, src MAC 001122334455; grant 3 cycles later → ack pulse; bytes 6-7 = 00 02; bytes 18-23 = 00 11 22 33 44 55; bytes 24-27 = C0 A8 00 03; 46 valid bytes; end on byte 45; dst_mac = 001122334455.
- Request: arp_request_ip_addr=C0A80001 → op bytes 00 01; THA all 00; TPA C0 A8 00 01; dst_mac = FFFFFFFFFFFF; bytes 28-45 = 00.
- Simultaneous reply and request in the same cycle → reply frame first; arp_request_ack only after END; two complete frames with ≥2 idle cycles between.
- rst pulsed at byte 20 of a frame → next cycle: valid=0, busy=0, no ack; a new request afterwards produces a full frame from byte 0.
- With ARP_TX_TIMEOUT_EN and GRANT_TIMEOUT=16: grant never asserted → arp_tx_timeout pulses 16 cycles after arp_tx_req rises, then IDLE.
- Operand stability: change arp_rec_source_ip_addr to 0 during SEND → transmitted TPA unchanged (C0A80003).

Source files
------------

// File: rtl/arp_pkg.sv
// Shared ARP constants, frame byte offsets and transmit FSM state encoding
// used by both the ARP transmit and receive paths.
package arp_pkg;

    localparam logic [15:0] ARP_HTYPE_ETH    = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4   = 16'h0800;
    localparam logic [7:0]  ARP_HLEN         = 8'h06;
    localparam logic [7:0]  ARP_PLEN         = 8'h04;
    localparam logic [15:0] ARP_REQUEST_CODE = 16'h0001;
    localparam logic [15:0] ARP_REPLY_CODE   = 16'h0002;
    localparam logic [47:0] ARP_BCAST_MAC    = 48'hFFFF_FFFF_FFFF;

    // Byte offsets of each field inside the 28-byte ARP body.
    localparam int ARP_OFF_HTYPE = 0;
    localparam int ARP_OFF_PTYPE = 2;
    localparam int ARP_OFF_HLEN  = 4;
    localparam int ARP_OFF_PLEN  = 5;
    localparam int ARP_OFF_OPER  = 6;
    localparam int ARP_OFF_SHA   = 8;
    localparam int ARP_OFF_SPA   = 14;
    localparam int ARP_OFF_THA   = 18;
    localparam int ARP_OFF_TPA   = 24;
    localparam int ARP_BODY_LEN  = 28;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'b0001,
        ST_WAIT_GRANT = 4'b0010,
        ST_SEND       = 4'b0100,
        ST_END        = 4'b1000
    } arp_tx_state_e;

endpackage

// File: rtl/arp_tx_if.sv
// Byte stream and handshake between the ARP transmit engine (master)
// and the MAC transmit arbiter (slave).
interface arp_tx_if;

    logic        arp_tx_req;
    logic        arp_tx_ready;
    logic [7:0]  arp_tx_data;
    logic        arp_tx_valid;
    logic        arp_tx_end;
    logic [47:0] arp_tx_dst_mac;

    modport master (
        output arp_tx_req, arp_tx_data, arp_tx_valid, arp_tx_end, arp_tx_dst_mac,
        input  arp_tx_ready
    );

    modport slave (
        input  arp_tx_req, arp_tx_data, arp_tx_valid, arp_tx_end, arp_tx_dst_mac,
        output arp_tx_ready
    );

endinterface

// File: rtl/arp_tx_mux.sv
// Combinational byte selector: maps the byte counter onto the latched ARP
// fields, returning zero for the padding bytes past the 28-byte body.
module arp_tx_mux
    import arp_pkg::*;
(
    input  logic [7:0]  cnt,
    input  logic [15:0] op,
    input  logic [47:0] sha,
    input  logic [31:0] spa,
    input  logic [47:0] tha,
    input  logic [31:0] tpa,
    output logic [7:0]  data
);

    logic [8*ARP_BODY_LEN-1:0] body;

    assign body = {ARP_HTYPE_ETH, ARP_PTYPE_IPV4, ARP_HLEN, ARP_PLEN,
                   op, sha, spa, tha, tpa};

    always_comb begin
        data = 8'h00;
        for (int i = 0; i < ARP_BODY_LEN; i++) begin
            if (cnt == 8'(i)) data = body[8*(ARP_BODY_LEN-1-i) +: 8];
        end
    end

endmodule

// File: rtl/arp_tx.sv
// ARP transmit engine: serialises ARP replies and requests into the MAC arbiter.
// Optional grant timeout enabled by defining ARP_TX_TIMEOUT_EN.
module arp_tx
    import arp_pkg::*;
#(
    parameter int PAYLOAD_LEN = 46
`ifdef ARP_TX_TIMEOUT_EN
    , parameter int GRANT_TIMEOUT = 1024
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] local_ip_addr,
    input  logic [47:0] local_mac_addr,
    input  logic        arp_reply_req,
    output logic        arp_reply_ack,
    input  logic [31:0] arp_rec_source_ip_addr,
    input  logic [47:0] arp_rec_source_mac_addr,
    input  logic        arp_request_req,
    output logic        arp_request_ack,
    input  logic [31:0] arp_request_ip_addr,
    arp_tx_if.master    tx,
    output logic        arp_tx_busy
`ifdef ARP_TX_TIMEOUT_EN
    , output logic      arp_tx_timeout
`endif
);

    localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_LEN - 1);

    arp_tx_state_e state, state_next;
    logic [7:0]    cnt;
    logic [15:0]   op_q;
    logic [47:0]   sha_q, tha_q, dst_mac_q;
    logic [31:0]   spa_q, tpa_q;
    logic          accept_reply, accept_request;

`ifdef ARP_TX_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(GRANT_TIMEOUT - 1);
    logic [15:0] tmo_cnt;
    logic        timeout_hit;
`endif

    always_comb begin
        state_next     = state;
        accept_reply   = 1'b0;
        accept_request = 1'b0;
`ifdef ARP_TX_TIMEOUT_EN
        timeout_hit    = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (arp_reply_req) begin
                    accept_reply = 1'b1;
                    state_next   = ST_WAIT_GRANT;
                end else if (arp_request_req) begin
                    accept_request = 1'b1;
                    state_next     = ST_WAIT_GRANT;
                end
            end
            ST_WAIT_GRANT: begin
                if (tx.arp_tx_ready) state_next = ST_SEND;
`ifdef ARP_TX_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
`endif
            end
            ST_SEND:  if (cnt == LAST_IDX) state_next = ST_END;
            ST_END:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Operands are captured once at accept so later input changes cannot
    // corrupt a frame already in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            cnt             <= 8'd0;
            arp_reply_ack   <= 1'b0;
            arp_request_ack <= 1'b0;
            op_q            <= '0;
            sha_q           <= '0;
            spa_q           <= '0;
            tha_q           <= '0;
            tpa_q           <= '0;
            dst_mac_q       <= '0;
        end else begin
            state           <= state_next;
            arp_reply_ack   <= accept_reply;
            arp_request_ack <= accept_request;
            cnt             <= (state == ST_SEND && state_next == ST_SEND) ? cnt + 8'd1 : 8'd0;
            if (accept_reply) begin
                op_q      <= ARP_REPLY_CODE;
                sha_q     <= local_mac_addr;
                spa_q     <= local_ip_addr;
                tha_q     <= arp_rec_source_mac_addr;
                tpa_q     <= arp_rec_source_ip_addr;
                dst_mac_q <= arp_rec_source_mac_addr;
            end else if (accept_request) begin
                op_q      <= ARP_REQUEST_CODE;
                sha_q     <= local_mac_addr;
                spa_q     <= local_ip_addr;
                tha_q     <= '0;
                tpa_q     <= arp_request_ip_addr;
                dst_mac_q <= ARP_BCAST_MAC;
            end
        end
    end

`ifdef ARP_TX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt        <= 16'd0;
            arp_tx_timeout <= 1'b0;
        end else begin
            tmo_cnt        <= (state == ST_WAIT_GRANT && state_next == ST_WAIT_GRANT) ? tmo_cnt + 16'd1 : 16'd0;
            arp_tx_timeout <= timeout_hit;
        end
    end
`endif

    arp_tx_mux u_mux (
        .cnt  (cnt),
        .op   (op_q),
        .sha  (sha_q),
        .spa  (spa_q),
        .tha  (tha_q),
        .tpa  (tpa_q),
        .data (tx.arp_tx_data)
    );

    assign tx.arp_tx_req     = (state == ST_WAIT_GRANT);
    assign tx.arp_tx_valid   = (state == ST_SEND);
    assign tx.arp_tx_end     = (state == ST_SEND) && (cnt == LAST_IDX);
    assign tx.arp_tx_dst_mac = dst_mac_q;
    assign arp_tx_busy       = (state != ST_IDLE);

endmodule
